// File: rtl/level_sequencer.sv
// Game-flow sequencer for the color_mapper playfield: banners, paced obstacle
// releases, hit detection and win/game-over, all counted in video frames.
module level_sequencer #(
   parameter int BANNER_FRAMES = 120,
   parameter int SPAWN_FRAMES  = 30,
   parameter int CLEAR_FRAMES  = 60,
   parameter int NUM_BLOCKS    = 10,
   parameter int NUM_RECTS     = 3
) (
   input  logic                  Clk,
   input  logic                  Reset,
   input  logic                  frame_tick,
   input  logic                  start,
   input  logic                  Collision,
   output logic                  level_one,
   output logic                  level_two,
   output logic [0:NUM_BLOCKS-1] block_ready,
   output logic [0:NUM_RECTS-1]  rect_ready,
   output logic                  game_over,
   output logic                  win,
   output logic [2:0]            state
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_BANNER1 = 3'd1,
      S_PLAY1   = 3'd2,
      S_BANNER2 = 3'd3,
      S_PLAY2   = 3'd4,
      S_OVER    = 3'd5,
      S_WIN     = 3'd6
   } state_t;

   localparam logic [9:0] BANNER_LAST = 10'(BANNER_FRAMES - 1);
   localparam logic [9:0] SPAWN_LAST  = 10'(SPAWN_FRAMES - 1);
   localparam logic [9:0] CLEAR_LAST  = 10'(CLEAR_FRAMES - 1);

   state_t                  state_q, state_d;
   logic [9:0]              frame_cnt_q, frame_cnt_d;
   logic [4:0]              released_q, released_d;
   logic                    hit_latch_q, hit_latch_d;
   logic [0:NUM_BLOCKS-1]   block_q, block_d;
   logic [0:NUM_RECTS-1]    rect_q, rect_d;
   logic                    level_one_q, level_one_d;
   logic                    level_two_q, level_two_d;
   logic                    game_over_q, game_over_d;
   logic                    win_q, win_d;

   logic hit_now;
   logic banner_done;
   logic clear_done;
   logic play_all;

   // A collision on the tick cycle itself counts for that tick.
   assign hit_now     = hit_latch_q | Collision;
   assign banner_done = frame_tick && (frame_cnt_q == BANNER_LAST);
   assign clear_done  = frame_tick && (frame_cnt_q == CLEAR_LAST);
   assign play_all    = (state_q == S_PLAY1) ? (released_q >= 5'(NUM_BLOCKS))
                                             : (released_q >= 5'(NUM_RECTS));

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q     <= S_IDLE;
         frame_cnt_q <= '0;
         released_q  <= '0;
         hit_latch_q <= 1'b0;
         block_q     <= '0;
         rect_q      <= '0;
         level_one_q <= 1'b0;
         level_two_q <= 1'b0;
         game_over_q <= 1'b0;
         win_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         frame_cnt_q <= frame_cnt_d;
         released_q  <= released_d;
         hit_latch_q <= hit_latch_d;
         block_q     <= block_d;
         rect_q      <= rect_d;
         level_one_q <= level_one_d;
         level_two_q <= level_two_d;
         game_over_q <= game_over_d;
         win_q       <= win_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE, S_OVER, S_WIN: if (start) state_d = S_BANNER1;
         S_BANNER1:             if (banner_done) state_d = S_PLAY1;
         S_BANNER2:             if (banner_done) state_d = S_PLAY2;
         S_PLAY1, S_PLAY2: begin
            if (frame_tick) begin
               if (hit_now)
                  state_d = S_OVER;
               else if (play_all && clear_done)
                  state_d = (state_q == S_PLAY1) ? S_BANNER2 : S_WIN;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Frame pacing, release bookkeeping and the obstacle enables.
   always_comb begin
      frame_cnt_d = frame_cnt_q;
      released_d  = released_q;
      hit_latch_d = 1'b0;
      block_d     = block_q;
      rect_d      = rect_q;
      case (state_q)
         S_IDLE, S_OVER, S_WIN: begin
            if (start) begin
               frame_cnt_d = '0;
               released_d  = '0;
               block_d     = '0;
               rect_d      = '0;
            end
         end
         S_BANNER1, S_BANNER2: begin
            if (frame_tick) begin
               if (banner_done) begin
                  frame_cnt_d = '0;
                  released_d  = 5'd1;
                  if (state_q == S_BANNER1) block_d[0] = 1'b1;
                  else                      rect_d[0]  = 1'b1;
               end else begin
                  frame_cnt_d = frame_cnt_q + 10'd1;
               end
            end
         end
         S_PLAY1, S_PLAY2: begin
            hit_latch_d = frame_tick ? 1'b0 : hit_now;
            // A hit freezes the playfield: nothing else moves on that tick.
            if (frame_tick && !hit_now) begin
               if (!play_all) begin
                  if (frame_cnt_q == SPAWN_LAST) begin
                     frame_cnt_d = '0;
                     released_d  = released_q + 5'd1;
                     if (state_q == S_PLAY1) begin
                        for (int i = 0; i < NUM_BLOCKS; i++)
                           if (5'(i) == released_q) block_d[i] = 1'b1;
                     end else begin
                        for (int i = 0; i < NUM_RECTS; i++)
                           if (5'(i) == released_q) rect_d[i] = 1'b1;
                     end
                  end else begin
                     frame_cnt_d = frame_cnt_q + 10'd1;
                  end
               end else if (clear_done) begin
                  frame_cnt_d = '0;
                  block_d     = '0;
                  rect_d      = '0;
               end else begin
                  frame_cnt_d = frame_cnt_q + 10'd1;
               end
            end
         end
         default: ;
      endcase
   end

   // Status outputs are decoded from the next state so they are registered.
   always_comb begin
      level_one_d = (state_d == S_BANNER1);
      level_two_d = (state_d == S_BANNER2);
      game_over_d = (state_d == S_OVER);
      win_d       = (state_d == S_WIN);
   end

   assign level_one   = level_one_q;
   assign level_two   = level_two_q;
   assign game_over   = game_over_q;
   assign win         = win_q;
   assign block_ready = block_q;
   assign rect_ready  = rect_q;
   assign state       = state_q;

endmodule

// File: tb/tb_level_sequencer.sv
// Directed bench for level_sequencer: a clean-run vector table replayed
// several times, plus hand-written hit, restart and reset sequences.
module tb_level_sequencer;

   localparam int NB = 10;
   localparam int NR = 3;

   logic          Clk = 1'b0;
   logic          Reset = 1'b0;
   logic          frame_tick = 1'b0;
   logic          start = 1'b0;
   logic          Collision = 1'b0;
   logic          level_one, level_two, game_over, win;
   logic [0:NB-1] block_ready;
   logic [0:NR-1] rect_ready;
   logic [2:0]    state;

   always #5 Clk = ~Clk;

   level_sequencer #(
      .BANNER_FRAMES(2), .SPAWN_FRAMES(3), .CLEAR_FRAMES(2),
      .NUM_BLOCKS(NB), .NUM_RECTS(NR)
   ) dut (
      .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick), .start(start),
      .Collision(Collision), .level_one(level_one), .level_two(level_two),
      .block_ready(block_ready), .rect_ready(rect_ready),
      .game_over(game_over), .win(win), .state(state)
   );

   typedef struct {
      int          tick;
      logic [2:0]  st;
      logic        l1, l2, go, wn;
      logic [15:0] bm, rm;
   } vec_t;

   vec_t tbl[13];
   int   n_pass = 0;
   int   n_total = 0;
   int   tcnt = 0;
   bit   coll_hold = 1'b0;

   // bit i of the mask is block_ready[i] / rect_ready[i]
   function automatic logic [15:0] bmask();
      logic [15:0] m = '0;
      for (int i = 0; i < NB; i++) m[i] = block_ready[i];
      return m;
   endfunction

   function automatic logic [15:0] rmask();
      logic [15:0] m = '0;
      for (int i = 0; i < NR; i++) m[i] = rect_ready[i];
      return m;
   endfunction

   task automatic check(input string nm, input logic [2:0] st, input logic l1, l2, go, wn,
                        input logic [15:0] bm, rm);
      logic [38:0] act, exp;
      act = {state, level_one, level_two, game_over, win, bmask(), rmask()};
      exp = {st, l1, l2, go, wn, bm, rm};
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s (tick %0d): got st=%0d l1=%b l2=%b go=%b win=%b blk=%h rect=%h, want st=%0d l1=%b l2=%b go=%b win=%b blk=%h rect=%h",
                    nm, tcnt, state, level_one, level_two, game_over, win, bmask(), rmask(),
                    st, l1, l2, go, wn, bm, rm);
   endtask

   // One frame: 7 quiet cycles then the tick cycle. cm pulses Collision for one
   // mid-frame cycle, ct raises it on the tick cycle, sm pulses start mid-frame.
   task automatic tick_once(input bit cm, input bit ct, input bit sm);
      for (int i = 0; i < 6; i++) begin
         @(negedge Clk);
         Collision = coll_hold | (cm && i == 3);
         start     = sm && i == 3;
      end
      @(negedge Clk);
      Collision  = coll_hold | ct;
      start      = 1'b0;
      frame_tick = 1'b1;
      @(negedge Clk);
      frame_tick = 1'b0;
      Collision  = 1'b0;
      tcnt++;
   endtask

   task automatic ticks_to(input int n);
      while (tcnt < n) tick_once(1'b0, 1'b0, 1'b0);
   endtask

   task automatic pulse_start(input bit with_tick);
      @(negedge Clk);
      start      = 1'b1;
      frame_tick = with_tick;
      @(negedge Clk);
      start      = 1'b0;
      frame_tick = 1'b0;
      tcnt       = 0;
   endtask

   // Clean run through to WIN; hold optionally keeps Collision high in banners.
   task automatic run_table(input bit hold, input string tag);
      int p = 0;
      while (tcnt < 41) begin
         coll_hold = hold && ((tcnt + 1 <= 2) || (tcnt + 1 >= 32 && tcnt + 1 <= 33));
         tick_once(1'b0, 1'b0, 1'b0);
         if (p < 13 && tbl[p].tick == tcnt) begin
            check($sformatf("%s_t%0d", tag, tcnt), tbl[p].st, tbl[p].l1, tbl[p].l2,
                  tbl[p].go, tbl[p].wn, tbl[p].bm, tbl[p].rm);
            p++;
         end
      end
      coll_hold = 1'b0;
   endtask

   initial begin
      tbl[0]  = '{1,  3'd1, 1, 0, 0, 0, 16'h000, 16'h0};
      tbl[1]  = '{2,  3'd2, 0, 0, 0, 0, 16'h001, 16'h0};
      tbl[2]  = '{4,  3'd2, 0, 0, 0, 0, 16'h001, 16'h0};
      tbl[3]  = '{5,  3'd2, 0, 0, 0, 0, 16'h003, 16'h0};
      tbl[4]  = '{29, 3'd2, 0, 0, 0, 0, 16'h3FF, 16'h0};
      tbl[5]  = '{30, 3'd2, 0, 0, 0, 0, 16'h3FF, 16'h0};
      tbl[6]  = '{31, 3'd3, 0, 1, 0, 0, 16'h000, 16'h0};
      tbl[7]  = '{32, 3'd3, 0, 1, 0, 0, 16'h000, 16'h0};
      tbl[8]  = '{33, 3'd4, 0, 0, 0, 0, 16'h000, 16'h1};
      tbl[9]  = '{36, 3'd4, 0, 0, 0, 0, 16'h000, 16'h3};
      tbl[10] = '{39, 3'd4, 0, 0, 0, 0, 16'h000, 16'h7};
      tbl[11] = '{40, 3'd4, 0, 0, 0, 0, 16'h000, 16'h7};
      tbl[12] = '{41, 3'd6, 0, 0, 0, 1, 16'h000, 16'h0};

      // Reset beats start, tick and Collision in the same cycle
      @(negedge Clk);
      Reset = 1'b1; start = 1'b1; frame_tick = 1'b1; Collision = 1'b1;
      @(negedge Clk);
      check("reset", 3'd0, 0, 0, 0, 0, 16'h0, 16'h0);
      Reset = 1'b0; start = 1'b0; frame_tick = 1'b0; Collision = 1'b0;
      ticks_to(5);
      check("idle_hold", 3'd0, 0, 0, 0, 0, 16'h0, 16'h0);

      // Clean run; the tick coincident with start must not count
      pulse_start(1'b1);
      check("start", 3'd1, 1, 0, 0, 0, 16'h0, 16'h0);
      run_table(1'b0, "clean");
      tick_once(1'b0, 1'b0, 1'b0);
      check("win_hold", 3'd6, 0, 0, 0, 1, 16'h0, 16'h0);

      // Restart from WIN, then a start in PLAY1 and a mid-frame hit
      pulse_start(1'b0);
      check("restart_win", 3'd1, 1, 0, 0, 0, 16'h0, 16'h0);
      ticks_to(2);
      tick_once(1'b0, 1'b0, 1'b1);
      tick_once(1'b0, 1'b0, 1'b0);
      check("start_ignored", 3'd2, 0, 0, 0, 0, 16'h001, 16'h0);
      ticks_to(6);
      tick_once(1'b1, 1'b0, 1'b0);
      check("hit_play1", 3'd5, 0, 0, 1, 0, 16'h003, 16'h0);
      ticks_to(9);
      check("over_frozen", 3'd5, 0, 0, 1, 0, 16'h003, 16'h0);

      // Restart from OVER, hit on the completion tick
      pulse_start(1'b0);
      check("restart_over", 3'd1, 1, 0, 0, 0, 16'h0, 16'h0);
      ticks_to(30);
      check("pre_complete", 3'd2, 0, 0, 0, 0, 16'h3FF, 16'h0);
      tick_once(1'b0, 1'b1, 1'b0);
      check("hit_on_complete", 3'd5, 0, 0, 1, 0, 16'h3FF, 16'h0);

      // Collision held during both banners is ignored
      pulse_start(1'b0);
      run_table(1'b1, "hold");

      // Hit on a PLAY2 tick cycle
      pulse_start(1'b0);
      ticks_to(34);
      tick_once(1'b0, 1'b1, 1'b0);
      check("hit_play2", 3'd5, 0, 0, 1, 0, 16'h0, 16'h1);

      // Reset mid-level at tick 15, then an exact rerun
      pulse_start(1'b0);
      ticks_to(14);
      @(negedge Clk);
      Reset = 1'b1; frame_tick = 1'b1; Collision = 1'b1;
      @(negedge Clk);
      Reset = 1'b0; frame_tick = 1'b0; Collision = 1'b0;
      check("reset_mid", 3'd0, 0, 0, 0, 0, 16'h0, 16'h0);
      pulse_start(1'b0);
      run_table(1'b0, "rerun");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
